// File: rtl/fetch_unit.sv
`default_nettype none
// ==========================================================================
// fetch_unit : 8-bit-PC instruction fetch stage (req/ack memory, valid/ready issue) | rev 1.0
// ==========================================================================
module fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              pc_jump,
  input  logic              pc_branch,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_err,
  output logic [15:0]       issue_count
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    ERR   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // Request is gated by rst so memory sees it drop the moment reset asserts.
  assign imem_req  = (state == FETCH) && !rst;
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      issue_count <= '0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            wait_cnt    <= '0;
            state       <= ISSUE;
          end else if (wait_cnt == LAST_WAIT) begin
            // Last acceptable cycle passed without an ack.
            fetch_err <= 1'b1;
            wait_cnt  <= '0;
            state     <= ERR;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            issue_count <= issue_count + 16'd1;
            pc          <= (pc_jump || pc_branch) ? target : pc + ADDR_W'(1);
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        ERR: begin
          fetch_err   <= 1'b1;
          instr_valid <= 1'b0;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// Bench for fetch_unit: directed decoder/memory stimulus, cycle-level model, literal spot checks.
module tb_fetch_unit;
  localparam int AW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [15:0]   imem_rdata = 16'h0;
  logic [15:0]   instr;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          pc_jump = 1'b0;
  logic          pc_branch = 1'b0;
  logic [AW-1:0] target = '0;
  logic [AW-1:0] pc;
  logic          fetch_err;
  logic [15:0]   issue_count;

  fetch_unit #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_jump(pc_jump), .pc_branch(pc_branch), .target(target),
    .pc(pc), .fetch_err(fetch_err), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Memory responder: mode 0 = answers after mem_wait cycles, 1 = dead,
  // 2 = ack toggling every cycle, 3 = ack stuck high.
  logic [15:0] mem [256];
  int mem_wait = 0;
  int mode = 0;
  int wcnt = 0;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      imem_ack = 1'b0;
      wcnt = 0;
    end else begin
      case (mode)
        1: imem_ack = 1'b0;
        2: imem_ack = ~imem_ack;
        3: imem_ack = 1'b1;
        default: begin
          if (imem_req && wcnt >= mem_wait) begin
            imem_ack = 1'b1;
            wcnt = 0;
          end else begin
            imem_ack = 1'b0;
            if (imem_req) wcnt++;
          end
        end
      endcase
    end
    imem_rdata = (imem_ack && mode == 0) ? mem[imem_addr] : 16'($urandom);
  end

  // Behavioural model: an instruction is either held for the decoder or being
  // requested; unanswered request cycles are counted against TO.
  logic [AW-1:0] m_pc;
  logic [15:0]   m_instr;
  logic          m_valid;
  logic          m_err;
  logic [15:0]   m_cnt;
  int            m_wait;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = '0; m_instr = '0; m_valid = 1'b0; m_err = 1'b0; m_cnt = '0; m_wait = 0;
    end else if (!m_err) begin
      if (!m_valid) begin
        if (imem_ack) begin
          m_instr = imem_rdata;
          m_valid = 1'b1;
          m_wait = 0;
        end else begin
          m_wait++;
          if (m_wait == TO) m_err = 1'b1;
        end
      end else if (instr_ready) begin
        m_cnt = m_cnt + 16'd1;
        m_pc = (pc_jump || pc_branch) ? target : m_pc + 8'd1;
        m_valid = 1'b0;
      end
    end
    #1;
    if (!rst) begin
      chk("m_imem_req", 32'(imem_req), 32'(!m_valid && !m_err));
      chk("m_imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("m_pc", 32'(pc), 32'(m_pc));
      chk("m_instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("m_instr", 32'(instr), 32'(m_instr));
      chk("m_fetch_err", 32'(fetch_err), 32'(m_err));
      chk("m_issue_count", 32'(issue_count), 32'(m_cnt));
    end
  end

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) chk("valid_timeout", 32'(instr_valid), 32'd1);
  endtask

  task automatic accept(input logic [15:0] exp_instr, input logic j, input logic b, input logic [AW-1:0] t);
    wait_valid();
    chk("instr_lit", 32'(instr), 32'(exp_instr));
    pc_jump = j;
    pc_branch = b;
    target = t;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    pc_jump = 1'b0;
    pc_branch = 1'b0;
    target = AW'($urandom);
  endtask

  logic [15:0] hold_instr;
  logic [AW-1:0] hold_pc;
  logic [15:0] hold_cnt;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h4000 | 16'(i);
    mem[0] = 16'h0123;
    mem[1] = 16'h8040;

    repeat (2) @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    chk("rst_issue_count", 32'(issue_count), 32'd0);
    #2 rst = 1'b0;

    // Zero-wait fetch of 0x0123 at 0, sequential advance.
    accept(16'h0123, 1'b0, 1'b0, 8'h00);
    chk("seq_addr", 32'(imem_addr), 32'h01);
    chk("seq_count", 32'(issue_count), 32'd1);

    accept(16'h8040, 1'b1, 1'b0, 8'h40);
    chk("jump_addr", 32'(imem_addr), 32'h40);
    chk("jump_pc", 32'(pc), 32'h40);

    // Taken branch whose target equals pc: self-loop re-fetch.
    accept(16'h4040, 1'b0, 1'b1, 8'h40);
    chk("branch_pc", 32'(pc), 32'h40);

    accept(16'h4040, 1'b0, 1'b0, 8'h99);
    chk("noredir_pc", 32'(pc), 32'h41);

    accept(16'h4041, 1'b1, 1'b0, 8'hFF);
    chk("jump_ff_pc", 32'(pc), 32'hFF);
    accept(16'h40FF, 1'b0, 1'b0, 8'h33);
    chk("wrap_addr", 32'(imem_addr), 32'h00);

    mem_wait = 2;
    accept(16'h0123, 1'b1, 1'b1, 8'h10);
    chk("both_pc", 32'(pc), 32'h10);
    chk("count7", 32'(issue_count), 32'd7);

    // Asynchronous reset while memory is inserting wait states.
    @(negedge clk);
    chk("wait_req", 32'(imem_req), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("arst_issue_count", 32'(issue_count), 32'd0);
    chk("arst_instr_valid", 32'(instr_valid), 32'd0);
    chk("arst_imem_req", 32'(imem_req), 32'd0);
    chk("arst_pc", 32'(pc), 32'd0);
    mem_wait = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;

    // Backpressure with noisy ack and toggling jump.
    wait_valid();
    chk("restart_instr", 32'(instr), 32'h0123);
    chk("restart_pc", 32'(pc), 32'h00);
    hold_instr = instr;
    hold_pc = pc;
    hold_cnt = issue_count;
    mode = 2;
    for (int k = 0; k < 5; k++) begin
      pc_jump = ~pc_jump;
      target = AW'($urandom);
      @(negedge clk);
      chk("hold_instr", 32'(instr), 32'(hold_instr));
      chk("hold_pc", 32'(pc), 32'(hold_pc));
      chk("hold_count", 32'(issue_count), 32'(hold_cnt));
      chk("hold_req", 32'(imem_req), 32'd0);
    end
    mode = 0;
    pc_jump = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("one_issue_count", 32'(issue_count), 32'd1);
    chk("one_issue_pc", 32'(pc), 32'h01);
    @(negedge clk);
    chk("one_issue_stable", 32'(issue_count), 32'd1);

    // Timeout: memory goes dead right after the accepting edge (cycle 0).
    wait_valid();
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    mode = 1;
    for (int k = 0; k <= TO; k++) begin
      chk("to_err", 32'(fetch_err), 32'(k == TO));
      chk("to_req", 32'(imem_req), 32'(k != TO));
      if (k < TO) @(negedge clk);
    end
    mode = 3;
    repeat (3) begin
      @(negedge clk);
      chk("late_ack_err", 32'(fetch_err), 32'd1);
      chk("late_ack_valid", 32'(instr_valid), 32'd0);
      chk("late_ack_req", 32'(imem_req), 32'd0);
    end
    #3 rst = 1'b1;
    #1;
    chk("err_clear", 32'(fetch_err), 32'd0);
    mode = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    wait_valid();
    chk("err_restart_pc", 32'(pc), 32'h00);
    chk("err_restart_instr", 32'(instr), 32'h0123);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 16-bit CPU: owns the 8-bit program counter, fetches 16-bit instruction words from instruction memory over a req/ack handshake, and presents them to the instruction decoder with a valid/ready handshake. The block is the other end of the decoder's control-flow outputs: it consumes `pc_jump`, `pc_branch` and the 8-bit target address the decoder produces, and redirects the PC accordingly. It also detects memory that never answers, and counts issued instructions.

## Interface
- `ADDR_W`, 8: PC / instruction memory address width; matches the decoder's 8-bit address field.
- `TIMEOUT`, 15: cycles `imem_req` may stay unacknowledged before the fetch error trips (≥1).
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `imem_req` output 1: fetch request to instruction memory.
- `imem_addr` output ADDR_W: fetch address (equals `pc`).
- `imem_ack` input 1: memory has valid data on `imem_rdata` this cycle.
- `imem_rdata` input 16: fetched instruction word.
- `instr` output 16: instruction presented to decoder.
- `instr_valid` output 1: `instr` is valid.
- `instr_ready` input 1: decoder/execute accepts `instr` this cycle.
- `pc_jump` input 1: decoder jump request for the presented instruction.
- `pc_branch` input 1: decoder taken-branch request for the presented instruction.
- `target` input ADDR_W: redirect address from decoder.
- `pc` output ADDR_W: address of the instruction being fetched/presented.
- `fetch_err` output 1: sticky memory timeout flag.
- `issue_count` output 16: number of instructions accepted since reset.

## Operation
- States: FETCH, ISSUE, ERR. Reset state FETCH.
- Reset values: `pc`=0, `instr`=0, `instr_valid`=0, `fetch_err`=0, `issue_count`=0, timeout counter=0; `imem_req`=0 while `rst` high.
- FETCH: `imem_req`=1, `imem_addr`=`pc`, held constant until ack. On `imem_ack`: register `imem_rdata` into `instr`, set `instr_valid`, clear timeout counter, go to ISSUE. Without ack: timeout counter increments; when it reaches TIMEOUT with still no ack, go to ERR.
- ISSUE: `imem_req`=0, `instr_valid`=1, `instr` stable. On `instr_ready`:
  - `issue_count` += 1, wrapping at 16 bits.
  - If `pc_jump | pc_branch`, then `pc` ← `target`; otherwise `pc` ← `pc`+1 modulo 2^ADDR_W (0xFF → 0x00).
  - Clear `instr_valid`; go to FETCH.
- ERR: `fetch_err`=1, `imem_req`=0, `instr_valid`=0. Exit only via reset.
- `pc_jump`, `pc_branch`, `target` are sampled only on the accepting edge in ISSUE (`instr_valid & instr_ready`). Otherwise they are ignored.
- Both `pc_jump` and `pc_branch` high: a single redirect to `target`.
- `target` == `pc`: legal self-loop; the same address is re-fetched.
- `imem_ack` outside FETCH is ignored; `imem_rdata` is ignored when `imem_ack` is low.

## Timing
- FETCH → ISSUE:
  - Ack is accepted combinationally in the same cycle `imem_req` rises.
  - Minimum latency from request to `instr_valid` is 1 cycle.
  - Each cycle of memory wait adds 1 cycle.
- Peak throughput: one instruction per 2 cycles (FETCH, ISSUE) with zero-wait memory and `instr_ready` high.
- Redirect: the `imem_addr` presented in the cycle after the accepting edge is `target`. There is no wrong-path fetch and nothing to flush.
- Backpressure: `instr_ready` low holds `instr`, `instr_valid`, `pc` unchanged indefinitely. No timeout in ISSUE.
- Timeout: with `imem_req` rising in cycle 0 and no ack, the last cycle in which an ack is accepted is cycle TIMEOUT−1. The block enters ERR at the edge ending cycle TIMEOUT−1, so `fetch_err`=1 from cycle TIMEOUT.
- Asynchronous reset mid-operation, in any state: all outputs take reset values immediately without waiting for `clk`. After `rst` deasserts, the first rising edge begins FETCH at address 0. A late ack from the aborted fetch arrives in FETCH and is indistinguishable; memory must drop ack during reset.

## Test plan
- Reset then zero-wait memory returning 0x0123 at addr 0:
  - `instr`=0x0123, `instr_valid`=1 one cycle after `imem_req`.
  - With `instr_ready`=1, the next `imem_addr`=0x01 and `issue_count`=1.
- Present 0x8040 with `pc_jump`=1, `target`=0x40, `instr_ready`=1 → next `imem_addr`=0x40 and `pc`=0x40. Repeat with `pc_branch`=1 → same result; with both low → `pc`+1.
- Force `pc`=0xFF via jump, accept without redirect → next `imem_addr`=0x00.
- Hold `instr_ready`=0 for 5 cycles in ISSUE with `imem_ack` and `pc_jump` toggling:
  - `instr`, `pc`, `issue_count` stable; `imem_req`=0.
  - Then one ready cycle → exactly one issue.
- Memory never acks, TIMEOUT=15:
  - `fetch_err` rises on cycle 15 after the request and `imem_req` falls.
  - A later ack does nothing; `rst` clears the error and fetch restarts at 0x00.
- Assert `rst` mid-wait with 2 memory wait states and `issue_count`=7 → `issue_count`=0, `instr_valid`=0, `imem_req`=0 before the next clock edge; restart at addr 0.
